// File: rtl/sync_async_patgen_mc.sv
// Multi-channel pulse pattern generator with byte-wide register file and optional syncrst start.
// Define PATGEN_SYNC_EN to enable the syncrst synchroniser and honour the synced input.
`timescale 1ns/1ps
module sync_async_patgen_mc #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             suspend,
  input  logic             rfg_write,
  input  logic [7:0]       rfg_write_address,
  input  logic [7:0]       rfg_write_data,
  input  logic             synced,
  input  logic             syncrst,
  output logic [NCH-1:0]   out,
  output logic             running,
  output logic             done,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Configuration survives rst so software can program it while the block is held.
  logic [CNT_W-1:0] runlen_r    = '0;
  logic [CNT_W-1:0] idelay_r    = '0;
  logic [CNT_W-1:0] clkfac_r    = '0;
  logic [CNT_W-1:0] high_len_r  = '0;
  logic [CNT_W-1:0] low_len_r   = '0;
  logic [15:0]      numpulses_r = '0;
  logic [NCH-1:0]   enable_r    = '0;
  logic [NCH-1:0]   invert_r    = '0;

  logic [1:0] lane;
  assign lane = rfg_write_address[1:0];

  function automatic logic [31:0] put_byte(input logic [31:0] cur, input logic [1:0] ln,
                                           input logic [7:0] d);
    logic [31:0] r;
    r = cur;
    r[{ln, 3'b000} +: 8] = d;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rfg_write) begin
      case (rfg_write_address[7:2])
        6'h00: runlen_r   <= CNT_W'(put_byte(32'(runlen_r), lane, rfg_write_data));
        6'h01: idelay_r   <= CNT_W'(put_byte(32'(idelay_r), lane, rfg_write_data));
        6'h02: clkfac_r   <= CNT_W'(put_byte(32'(clkfac_r), lane, rfg_write_data));
        6'h03: high_len_r <= CNT_W'(put_byte(32'(high_len_r), lane, rfg_write_data));
        6'h04: low_len_r  <= CNT_W'(put_byte(32'(low_len_r), lane, rfg_write_data));
        6'h05: if (!lane[1]) numpulses_r <= 16'(put_byte(32'(numpulses_r), lane, rfg_write_data));
        6'h06: enable_r   <= NCH'(put_byte(32'(enable_r), lane, rfg_write_data));
        6'h07: invert_r   <= NCH'(put_byte(32'(invert_r), lane, rfg_write_data));
        default: ;
      endcase
    end
  end

  logic start_ok;

`ifdef PATGEN_SYNC_EN
  logic sync_ff1, sync_ff2, sync_prev;

  // History keeps advancing during suspend so edges seen then are consumed, not queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff1  <= 1'b0;
      sync_ff2  <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_ff1  <= syncrst;
      sync_ff2  <= sync_ff1;
      sync_prev <= sync_ff2;
    end
  end

  assign start_ok = synced ? (sync_ff2 & ~sync_prev) : 1'b1;
`else
  logic unused_sync;
  assign unused_sync = synced ^ syncrst;
  assign start_ok    = 1'b1;
`endif

  state_t           state;
  logic [CNT_W-1:0] divider, phase_cnt, cur_clkfac, cur_high, cur_low, run_left;
  logic [15:0]      pulse_left;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      divider    <= '0;
      phase_cnt  <= '0;
      pulse_left <= '0;
      cur_clkfac <= '0;
      cur_high   <= '0;
      cur_low    <= '0;
      run_left   <= runlen_r;
    end else if (!suspend) begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state      <= S_DELAY;
            divider    <= clkfac_r;
            cur_clkfac <= clkfac_r;
            cur_high   <= high_len_r;
            cur_low    <= low_len_r;
            pulse_left <= (numpulses_r == 16'd0) ? 16'd0 : numpulses_r - 16'd1;
            phase_cnt  <= len_m1(idelay_r);
          end
        end
        S_DELAY, S_HIGH, S_LOW: begin
          if (divider != '0) begin
            divider <= divider - 1'b1;
          end else begin
            divider <= cur_clkfac;
            if (phase_cnt != '0) begin
              phase_cnt <= phase_cnt - 1'b1;
            end else begin
              case (state)
                S_DELAY: begin
                  state     <= S_HIGH;
                  phase_cnt <= len_m1(cur_high);
                end
                S_HIGH: begin
                  if (pulse_left != 16'd0) begin
                    state      <= S_LOW;
                    pulse_left <= pulse_left - 16'd1;
                    phase_cnt  <= len_m1(cur_low);
                  end else if (run_left == CNT_W'(1)) begin
                    state <= S_DONE;
                  end else begin
                    // run_left of zero means an unbounded run.
                    if (run_left != '0) run_left <= run_left - 1'b1;
                    state <= S_IDLE;
                  end
                end
                default: begin
                  state     <= S_HIGH;
                  phase_cnt <= len_m1(cur_high);
                end
              endcase
            end
          end
        end
        default: state <= S_DONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else if (!suspend) begin
      out <= ({NCH{state == S_HIGH}} & enable_r) ^ invert_r;
    end
  end

  assign running   = (state == S_DELAY) || (state == S_HIGH) || (state == S_LOW);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_sync_async_patgen_mc.sv
// Directed bench for sync_async_patgen_mc: timing, masks, suspend, reset and start modes.
`timescale 1ns/1ps
module tb_sync_async_patgen_mc;
  localparam int NCH   = 4;
  localparam int CNT_W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           suspend = 1'b0;
  logic           rfg_write = 1'b0;
  logic [7:0]     rfg_write_address = '0;
  logic [7:0]     rfg_write_data = '0;
  logic           synced = 1'b0;
  logic           syncrst = 1'b0;
  logic [NCH-1:0] out;
  logic           running, done;
  logic [2:0]     state_dbg;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  logic [3:0] t3_exp [6];

  always #5 clk = ~clk;

  sync_async_patgen_mc #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .suspend(suspend), .rfg_write(rfg_write),
    .rfg_write_address(rfg_write_address), .rfg_write_data(rfg_write_data),
    .synced(synced), .syncrst(syncrst), .out(out), .running(running),
    .done(done), .state_dbg(state_dbg)
  );

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [7:0] a, input logic [7:0] d);
    rfg_write = 1'b1;
    rfg_write_address = a;
    rfg_write_data = d;
    clk_n(1);
    rfg_write = 1'b0;
  endtask

  task automatic wr_reg(input logic [7:0] base, input logic [31:0] v);
    for (int b = 0; b < 4; b++) wr_byte(base + 8'(b), v[8*b +: 8]);
  endtask

  // Holds rst while programming so the run counter latches the new runlen.
  task automatic cfg(input logic [31:0] ck, input logic [31:0] id, input logic [31:0] hi,
                     input logic [31:0] lo, input logic [31:0] np, input logic [31:0] rl,
                     input logic [31:0] en, input logic [31:0] iv);
    rst = 1'b1;
    wr_reg(8'h08, ck);
    wr_reg(8'h04, id);
    wr_reg(8'h0C, hi);
    wr_reg(8'h10, lo);
    wr_reg(8'h14, np);
    wr_reg(8'h00, rl);
    wr_reg(8'h18, en);
    wr_reg(8'h1C, iv);
    clk_n(1);
  endtask

  initial begin
    t3_exp = '{4'h2, 4'h2, 4'h7, 4'h2, 4'h7, 4'h2};

    // Single pulse: 2-clock delay, 3 clocks high, then done
    cfg(0, 2, 3, 0, 1, 1, 32'hF, 0);
    check("rst_out", 32'(out), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      clk_n(1);
      check("t1_out", 32'(out), (i >= 4 && i <= 6) ? 32'hF : 32'h0);
      if (i == 3) check("t1_running", 32'(running), 32'h1);
    end
    check("t1_done", 32'(done), 32'h1);
    check("t1_running_end", 32'(running), 32'h0);
    syncrst = 1'b1;
    clk_n(3);
    syncrst = 1'b0;
    clk_n(5);
    check("t1_done_hold", 32'(done), 32'h1);
    check("t1_out_hold", 32'(out), 32'h0);

    // Three pulses, clkfac=1: 4 clocks high, 2 clocks low gap
    cfg(1, 0, 2, 1, 3, 1, 32'hF, 0);
    rst = 1'b0;
    for (int i = 1; i <= 21; i++) begin
      clk_n(1);
      check("t2_out", 32'(out),
            ((i >= 4 && i <= 7) || (i >= 10 && i <= 13) || (i >= 16 && i <= 19)) ? 32'hF : 32'h0);
      check("t2_running", 32'(running), (i <= 18) ? 32'h1 : 32'h0);
    end
    check("t2_done", 32'(done), 32'h1);

    // Masks, with zero high/low lengths acting as one tick
    cfg(0, 0, 0, 0, 2, 1, 32'h5, 32'h2);
    check("t3_out_rst", 32'(out), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      clk_n(1);
      check("t3_out", 32'(out), 32'(t3_exp[i]));
    end
    rst = 1'b1;
    clk_n(1);
    check("t3_out_rst2", 32'(out), 32'h0);
    check("t3_done_rst", 32'(done), 32'h0);

    // Suspend for 10 clocks mid-HIGH stretches the pulse by 10
    cfg(0, 0, 5, 0, 1, 1, 32'hF, 0);
    rst = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      clk_n(1);
      check("t4_out", 32'(out), (i >= 3 && i <= 17) ? 32'hF : 32'h0);
      check("t4_done", 32'(done), (i >= 17) ? 32'h1 : 32'h0);
      if (i == 4) suspend = 1'b1;
      if (i == 8) syncrst = 1'b1;
      if (i == 10) syncrst = 1'b0;
      if (i == 14) suspend = 1'b0;
    end

    // Infinite run, then reset mid-HIGH and clean restart
    cfg(0, 0, 2, 0, 1, 0, 32'hF, 0);
    rst = 1'b0;
    for (int i = 1; i <= 23; i++) begin
      clk_n(1);
      check("t5_out", 32'(out), (i >= 3 && (i % 4 == 3 || i % 4 == 0)) ? 32'hF : 32'h0);
      check("t5_done", 32'(done), 32'h0);
    end
    rst = 1'b1;
    clk_n(1);
    check("t5_rst_out", 32'(out), 32'h0);
    check("t5_rst_running", 32'(running), 32'h0);
    rst = 1'b0;
    clk_n(1);
    check("t5_restart_running", 32'(running), 32'h1);
    check("t5_restart_out0", 32'(out), 32'h0);
    clk_n(2);
    check("t5_restart_out1", 32'(out), 32'hF);

`ifdef PATGEN_SYNC_EN
    // Synced starts: each set begins 3 clocks after a syncrst rise
    cfg(0, 2, 1, 0, 1, 2, 32'hF, 0);
    synced = 1'b1;
    rst = 1'b0;
    clk_n(5);
    check("ts_idle_wait", 32'(running), 32'h0);
    for (int s = 0; s < 2; s++) begin
      syncrst = 1'b1;
      clk_n(2);
      check("ts_not_yet", 32'(running), 32'h0);
      clk_n(1);
      check("ts_started", 32'(running), 32'h1);
      syncrst = 1'b0;
      clk_n(2);
      check("ts_delay_out", 32'(out), 32'h0);
      clk_n(1);
      check("ts_pulse_out", 32'(out), 32'hF);
      check("ts_running_end", 32'(running), 32'h0);
      check("ts_done", 32'(done), (s == 1) ? 32'h1 : 32'h0);
      clk_n(1);
      check("ts_after_out", 32'(out), 32'h0);
      clk_n(80);
    end
    syncrst = 1'b1;
    clk_n(3);
    syncrst = 1'b0;
    clk_n(5);
    check("ts_third_running", 32'(running), 32'h0);
    check("ts_third_done", 32'(done), 32'h1);

    // A syncrst edge while suspended must not start a set
    cfg(0, 0, 1, 0, 1, 1, 32'hF, 0);
    rst = 1'b0;
    suspend = 1'b1;
    clk_n(2);
    syncrst = 1'b1;
    clk_n(3);
    syncrst = 1'b0;
    clk_n(3);
    suspend = 1'b0;
    clk_n(6);
    check("ts_susp_running", 32'(running), 32'h0);
    check("ts_susp_state", 32'(state_dbg), 32'h0);
`else
    // Without the synchroniser, synced is ignored and the block free-runs
    cfg(0, 0, 1, 0, 1, 1, 32'hF, 0);
    synced = 1'b1;
    rst = 1'b0;
    clk_n(1);
    check("tn_free_running", 32'(running), 32'h1);
    clk_n(2);
    check("tn_free_out", 32'(out), 32'hF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_async_patgen_mc.md
SYNC_ASYNC_PATGEN_MC -- requirements
Module: sync_async_patgen_mc

Interface
REQ-001 Parameter NCH, default 4, number of output channels (1..32).
REQ-002 Parameter CNT_W, default 16, width of runlen/idelay/clkfac/high_len/low_len (8..32).
REQ-003 clk  input  1  sole clock, all logic on posedge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 suspend  input  1  freezes pattern execution while high.
REQ-006 rfg_write  input  1  register write strobe, one byte per cycle.
REQ-007 rfg_write_address  input  8  byte address of write.
REQ-008 rfg_write_data  input  8  write data.
REQ-009 synced  input  1  1 = each pulse set starts on a syncrst rising edge; 0 = free-running.
REQ-010 syncrst  input  1  asynchronous external start reference.
REQ-011 out  output  NCH  registered per-channel pattern output.
REQ-012 running  output  1  high in DELAY, HIGH or LOW state.
REQ-013 done  output  1  high in DONE state.

Function
REQ-014 Register map, little-endian byte lanes, bytes above field width ignored: 0x00-03 runlen, 0x04-07 idelay, 0x08-0B clkfac, 0x0C-0F high_len, 0x10-13 low_len, 0x14-15 numpulses (16 bit), 0x18-1B enable mask, 0x1C-1F invert mask; other addresses ignored.
REQ-015 Config registers power up 0, are NOT cleared by rst, and accept writes in every state including during rst and suspend.
REQ-016 Timebase: divider reloads clkfac on entry to DELAY and after each tick; tick asserted on a non-suspended cycle where divider == 0; tick period = clkfac+1 clocks.
REQ-017 States IDLE, DELAY, HIGH, LOW, DONE; transitions occur only on ticks except IDLE exit.
REQ-018 IDLE -> DELAY: synced=1 on detected syncrst rising edge; synced=0 on the first non-suspended cycle.
REQ-019 DELAY lasts idelay ticks, pattern low; idelay=0 enters HIGH on first tick.
REQ-020 HIGH lasts max(high_len,1) ticks, pattern high; LOW lasts max(low_len,1) ticks, pattern low.
REQ-021 Pulse set = max(numpulses,1) HIGH phases separated by LOW phases; no LOW after the last HIGH.
REQ-022 After the last HIGH: pulse set counted; if runlen!=0 and count reaches runlen -> DONE, else -> IDLE.
REQ-023 runlen=0 means infinite; run counter CNT_W bits, latched from runlen at rst release.
REQ-024 idelay, high_len, low_len, numpulses, clkfac sampled at each DELAY entry; mid-set writes take effect next set.
REQ-025 out[i] <= (pattern & enable[i]) ^ invert[i], one-cycle register latency from state.
REQ-026 DONE holds pattern low until rst; syncrst edges ignored.
REQ-027 suspend: divider, counters, state, out frozen; syncrst edges arriving while suspended are discarded.
REQ-028 syncrst edge in DELAY/HIGH/LOW ignored (no restart, no queue).

Reset
REQ-029 rst forces state IDLE, out=0, running=0, done=0, divider and counters cleared, edge detector history cleared.
REQ-030 rst mid-pulse ends output on the next cycle; no partial pulse resumes.
REQ-031 rst dominates suspend.

Configuration
REQ-032 Macro PATGEN_SYNC_EN: defined -> syncrst passes a 2-flop synchroniser plus edge detector (start edge seen 3 cycles after syncrst rise) and synced is honoured.
REQ-033 PATGEN_SYNC_EN undefined -> synchroniser omitted, synced and syncrst ignored, block always free-running.

Verification
REQ-034 clkfac=0, idelay=2, high_len=3, numpulses=1, runlen=1, synced=0, enable=0xF -> out=0xF for exactly 3 clocks after 2-clock delay, then done=1.
REQ-035 numpulses=3, high_len=2, low_len=1, clkfac=1 -> 3 pulses each 4 clocks high, 2 clocks low gap, running drops after third.
REQ-036 synced=1, runlen=2, syncrst pulses at t=0 and t=100 (with PATGEN_SYNC_EN) -> each set starts 3 clocks after edge plus idelay; done after second; third edge ignored.
REQ-037 enable=0x5, invert=0x2 -> during HIGH out=0x7, in LOW out=0x2, under rst out=0x0.
REQ-038 suspend asserted 10 clocks mid-HIGH -> HIGH stretched by exactly 10 clocks; syncrst edge during suspend produces no start.
REQ-039 runlen=0, async -> pulse sets repeat indefinitely, done never set; rst mid-HIGH -> out=0 next cycle, restarts cleanly.
